// File: rtl/axis_pattern_source_if.sv
// Byte-wide valid/ready stream link between the pattern source and its sink.
interface axis_pattern_source_if;
   logic [7:0] odata;
   logic       ovalid;
   logic       oready;
   logic       olast;

   modport master (output odata, output ovalid, output olast, input oready);
   modport slave  (input odata, input ovalid, input olast, output oready);
endinterface

// File: rtl/axis_pattern_source.sv
// Bounded-burst stream source emitting counter or Galois-LFSR beats.
// Optional inter-beat throttle gaps are enabled by AXIS_PATTERN_SOURCE_THROTTLE_EN.
//
// Handshake: a beat transfers on a rising edge where ovalid && oready. ovalid is a
// pure function of registered state (never of oready), and once raised it holds,
// together with odata and olast, until that transfer happens.
module axis_pattern_source #(
   parameter int LEN_WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 mode,
   input  logic [7:0]           seed,
   input  logic [LEN_WIDTH-1:0] length,
`ifdef AXIS_PATTERN_SOURCE_THROTTLE_EN
   input  logic [3:0]           throttle,
`endif
   axis_pattern_source_if.master axis,
   output logic                 busy,
   output logic                 done,
   output logic [LEN_WIDTH-1:0] sent,
   output logic [1:0]           fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

   state_t               state, state_n;
   logic [7:0]           data, data_n;
   logic [LEN_WIDTH-1:0] remaining, remaining_n;
   logic [LEN_WIDTH-1:0] count, count_n;
   logic                 pat_mode, pat_mode_n;
`ifdef AXIS_PATTERN_SOURCE_THROTTLE_EN
   logic [3:0]           gap, gap_n;
`endif

   // Galois LFSR with taps 0xB8 never maps a nonzero value to zero.
   function automatic logic [7:0] next_pattern(input logic m, input logic [7:0] v);
      if (!m)
         return v + 8'd1;
      else if (v[0])
         return (v >> 1) ^ 8'hB8;
      else
         return v >> 1;
   endfunction

   always_comb begin
      state_n     = state;
      data_n      = data;
      remaining_n = remaining;
      count_n     = count;
      pat_mode_n  = pat_mode;
`ifdef AXIS_PATTERN_SOURCE_THROTTLE_EN
      gap_n       = gap;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               pat_mode_n = mode;
               count_n    = '0;
               if (length == '0) begin
                  state_n = FIN;
               end else begin
                  state_n     = RUN;
                  remaining_n = length;
                  data_n      = (mode && seed == 8'h00) ? 8'h01 : seed;
               end
            end
         end
         RUN: begin
            if (axis.oready) begin
               count_n     = count + ONE;
               remaining_n = remaining - ONE;
               data_n      = next_pattern(pat_mode, data);
               if (remaining == ONE) begin
                  state_n = FIN;
               end
`ifdef AXIS_PATTERN_SOURCE_THROTTLE_EN
               else if (throttle != 4'd0) begin
                  state_n = GAP;
                  gap_n   = throttle;
               end
`endif
            end
         end
         GAP: begin
`ifdef AXIS_PATTERN_SOURCE_THROTTLE_EN
            gap_n = gap - 4'd1;
            if (gap == 4'd1) state_n = RUN;
`else
            state_n = IDLE;
`endif
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state     <= IDLE;
         data      <= 8'h00;
         remaining <= '0;
         count     <= '0;
         pat_mode  <= 1'b0;
`ifdef AXIS_PATTERN_SOURCE_THROTTLE_EN
         gap       <= 4'd0;
`endif
      end else begin
         state     <= state_n;
         data      <= data_n;
         remaining <= remaining_n;
         count     <= count_n;
         pat_mode  <= pat_mode_n;
`ifdef AXIS_PATTERN_SOURCE_THROTTLE_EN
         gap       <= gap_n;
`endif
      end
   end

   assign axis.odata  = data;
   assign axis.ovalid = (state == RUN);
   assign axis.olast  = (state == RUN) && (remaining == ONE);
   assign busy        = (state == RUN) || (state == GAP);
   assign done        = (state == FIN);
   assign sent        = count;
   assign fsm_state   = state;

   a_hold_until_transfer: assert property (@(posedge clock) disable iff (!resetn)
      (axis.ovalid && !axis.oready) |=> (axis.ovalid && $stable(axis.odata) && $stable(axis.olast)));
   a_last_needs_valid: assert property (@(posedge clock) disable iff (!resetn)
      axis.olast |-> axis.ovalid);
   a_done_without_valid: assert property (@(posedge clock) disable iff (!resetn)
      done |-> (!axis.ovalid && !busy));

endmodule

// File: tb/tb_axis_pattern_source.sv
// Randomized scoreboard bench for axis_pattern_source (both throttle builds).
module tb_axis_pattern_source;
   localparam int LW        = 8;
   localparam int RM_ONE    = 0;
   localparam int RM_RAND   = 1;
   localparam int RM_SCRIPT = 2;
   localparam int BUDGET    = 2000;

   logic          clock = 1'b0;
   logic          resetn;
   logic          start;
   logic          mode;
   logic [7:0]    seed;
   logic [LW-1:0] length;
   logic [3:0]    throttle;
   logic          oready;
   logic          busy;
   logic          done;
   logic [LW-1:0] sent;
   logic [1:0]    fsm_state;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];
   bit         vhist[$];
   bit         zero_ok = 1'b0;

   logic       prev_pend = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_last = 1'b0;
   logic       prev_last_xfer = 1'b0;
   logic       prev_mid_xfer = 1'b0;
   logic [3:0] prev_thr = 4'd0;

   axis_pattern_source_if axis();
   assign axis.oready = oready;

   axis_pattern_source #(.LEN_WIDTH(LW)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .start     (start),
      .mode      (mode),
      .seed      (seed),
      .length    (length),
`ifdef AXIS_PATTERN_SOURCE_THROTTLE_EN
      .throttle  (throttle),
`endif
      .axis      (axis),
      .busy      (busy),
      .done      (done),
      .sent      (sent),
      .fsm_state (fsm_state)
   );

   always #5 clock = ~clock;

   // Reference: beat i of a burst, straight from the pattern definitions.
   function automatic logic [7:0] model_beat(input bit m, input logic [7:0] s, input int i);
      int v;
      if (!m) begin
         v = (int'(s) + i) % 256;
      end else begin
         v = (s == 8'h00) ? 1 : int'(s);
         for (int k = 0; k < i; k++)
            v = (v % 2 == 1) ? ((v / 2) ^ 184) : (v / 2);
      end
      return 8'(v);
   endfunction

   function automatic logic pick_ready(input int rmode, input int idx);
      bit script[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      if (rmode == RM_ONE)  return 1'b1;
      if (rmode == RM_RAND) return ($urandom_range(0, 3) != 0);
      if (idx < 6)          return script[idx];
      return 1'b1;
   endfunction

   function automatic logic [3:0] rand_thr();
`ifdef AXIS_PATTERN_SOURCE_THROTTLE_EN
      return 4'($urandom_range(0, 3));
`else
      return 4'd0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, expv);
      end
   endtask

   task automatic scramble_cmd();
      mode   = 1'($urandom_range(0, 1));
      seed   = 8'($urandom_range(0, 255));
      length = LW'($urandom_range(0, 255));
   endtask

   task automatic run_burst(input bit m, input logic [7:0] s, input int len, input int rmode,
                            input bit pester, input logic [3:0] thr, input bit thr_rand);
      int idx;
      int cyc;
      @(posedge clock); #1;
      for (int i = 0; i < len; i++)
         exp_q.push_back({(i == len - 1), model_beat(m, s, i)});
      vhist.delete();
      zero_ok  = (len == 0);
      start    = 1'b1;
      mode     = m;
      seed     = s;
      length   = LW'(len);
      throttle = thr;
      oready   = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      start  = 1'b0;
      scramble_cmd();
      oready = pick_ready(rmode, 0);
      idx    = 1;
      @(negedge clock);
      vhist.push_back(axis.ovalid);
      if (len == 0) begin
         check("zero_len_done", done, 1'b1);
         check("zero_len_valid", axis.ovalid, 1'b0);
      end else begin
         check("first_beat_valid", axis.ovalid, 1'b1);
         check("first_beat_data", axis.odata, model_beat(m, s, 0));
      end
      cyc = 0;
      while (!done && cyc < BUDGET) begin
         @(posedge clock); #1;
         start = pester ? 1'($urandom_range(0, 1)) : 1'b0;
         scramble_cmd();
         oready = pick_ready(rmode, idx);
         idx++;
         if (thr_rand) throttle = rand_thr();
         @(negedge clock);
         vhist.push_back(axis.ovalid);
         cyc++;
      end
      if (!done) begin
         errors++;
         $display("FAIL done_timeout len=%0d got=no_done expected=done", len);
      end
      check("sent_at_done", sent, LW'(len));
      check("busy_at_done", busy, 1'b0);
      @(posedge clock); #1;
      start   = 1'b0;
      zero_ok = 1'b0;
   endtask

   // Monitor: scoreboard pops, stream-rule checks and done-pulse placement.
   always @(negedge clock) begin
      if (!resetn) begin
         prev_pend      <= 1'b0;
         prev_last_xfer <= 1'b0;
         prev_mid_xfer  <= 1'b0;
      end else begin
         if (prev_pend) begin
            check("hold_valid", axis.ovalid, 1'b1);
            check("hold_data", {axis.olast, axis.odata}, {prev_last, prev_data});
         end
         if (prev_mid_xfer && prev_thr == 4'd0)
            check("no_bubble", axis.ovalid, 1'b1);
         if (prev_last_xfer)
            check("done_after_last", done, 1'b1);
         else if (done && !zero_ok)
            check("unexpected_done", done, 1'b0);
         if (axis.ovalid && axis.oready) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat got=%0h expected=none", {axis.olast, axis.odata});
            end else begin
               check("beat", {axis.olast, axis.odata}, exp_q.pop_front());
            end
         end
         prev_pend      <= axis.ovalid && !axis.oready;
         prev_data      <= axis.odata;
         prev_last      <= axis.olast;
         prev_last_xfer <= axis.ovalid && axis.oready && axis.olast;
         prev_mid_xfer  <= axis.ovalid && axis.oready && !axis.olast;
         prev_thr       <= throttle;
      end
   end

   initial begin
      resetn   = 1'b0;
      start    = 1'b0;
      mode     = 1'b0;
      seed     = 8'h00;
      length   = '0;
      throttle = 4'd0;
      oready   = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_valid", axis.ovalid, 1'b0);
      check("rst_last", axis.olast, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_sent", sent, '0);
      check("rst_data", axis.odata, 8'h00);
      check("rst_state", fsm_state, 2'd0);
      @(posedge clock); #1;
      resetn = 1'b1;

      run_burst(1'b0, 8'hFE, 4, RM_ONE, 1'b0, 4'd0, 1'b0);
      run_burst(1'b1, 8'h01, 3, RM_SCRIPT, 1'b0, 4'd0, 1'b0);
      run_burst(1'b0, 8'h55, 0, RM_ONE, 1'b0, 4'd0, 1'b0);
      run_burst(1'b0, 8'h30, 5, RM_RAND, 1'b1, 4'd0, 1'b0);
      run_burst(1'b1, 8'h00, 2, RM_ONE, 1'b0, 4'd0, 1'b0);

      // Abort a long burst with a two-cycle reset.
      @(posedge clock); #1;
      for (int i = 0; i < 20; i++)
         exp_q.push_back({(i == 19), model_beat(1'b0, 8'h10, i)});
      start  = 1'b1;
      mode   = 1'b0;
      seed   = 8'h10;
      length = LW'(20);
      @(posedge clock); #1;
      start  = 1'b0;
      oready = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      resetn = 1'b0;
      exp_q.delete();
      @(posedge clock);
      @(negedge clock);
      check("abort_valid", axis.ovalid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_sent", sent, '0);
      check("abort_done", done, 1'b0);
      @(posedge clock); #1;
      resetn = 1'b1;
      @(negedge clock);
      check("post_abort_done", done, 1'b0);

      run_burst(1'b1, 8'hC3, 6, RM_RAND, 1'b0, 4'd0, 1'b0);

`ifdef AXIS_PATTERN_SOURCE_THROTTLE_EN
      begin
         bit want[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
         run_burst(1'b0, 8'h20, 3, RM_ONE, 1'b0, 4'd2, 1'b0);
         check("throttle_len", vhist.size(), 8);
         for (int i = 0; i < 8 && i < vhist.size(); i++)
            check("throttle_valid", vhist[i], want[i]);
      end
`endif

      for (int b = 0; b < 40; b++) begin
         int len;
         len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
         run_burst(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), len,
                   $urandom_range(0, 1), 1'($urandom_range(0, 1)), rand_thr(), 1'b1);
      end

      repeat (4) @(posedge clock);
      @(negedge clock);
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
